// File: rtl/seq_multiplier_pkg.sv
// seq_multiplier_pkg: shared widths, iteration count and FSM encoding for the sequential multiplier
package seq_multiplier_pkg;
    localparam int DATA_W = 16;
    localparam int OP_W = 8;
    localparam int ITER = OP_W;
    localparam int CNT_W = $clog2(ITER);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/seq_multiplier_if.sv
// seq_multiplier_if: start/busy/done handshake and operand/result bus of the multiplier
interface seq_multiplier_if #(parameter int DATA_W = seq_multiplier_pkg::DATA_W);
    logic start;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] product;
    logic busy;
    logic done;
    logic zero;
    modport master (output start, a, b, input product, busy, done, zero);
    modport slave (input start, a, b, output product, busy, done, zero);
endinterface

// File: rtl/seq_multiplier_sign_mag8.sv
// sign_mag8: splits an 8-bit signed value into its sign and 8-bit unsigned magnitude
module sign_mag8 (
    input  logic [7:0] value,
    output logic       sign,
    output logic [7:0] mag
);
    assign sign = value[7];
    assign mag = value[7] ? -value : value;
endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative signed 8x8 sign-magnitude shift-add multiplier, one partial product per clock.
// Define MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are all zero.
module seq_multiplier #(
    parameter int DATA_W = seq_multiplier_pkg::DATA_W,
    parameter int OP_W = seq_multiplier_pkg::OP_W
) (
    input logic clk,
    input logic reset,
    seq_multiplier_if.slave bus
);
    import seq_multiplier_pkg::*;
    state_t state;
    logic a_sign, b_sign, neg, busy, done, last;
    logic [OP_W-1:0] a_mag, b_mag, mcand, mplier;
    logic [DATA_W-1:0] acc, acc_next, product;
    logic [CNT_W-1:0] count;
    wire unused_hi = ^{bus.a[DATA_W-1:OP_W], bus.b[DATA_W-1:OP_W]};
    sign_mag8 u_sm_a (.value(bus.a[OP_W-1:0]), .sign(a_sign), .mag(a_mag));
    sign_mag8 u_sm_b (.value(bus.b[OP_W-1:0]), .sign(b_sign), .mag(b_mag));
    assign acc_next = mplier[0] ? acc + (DATA_W'(mcand) << count) : acc;
`ifdef MULT_EARLY_TERM_EN
    assign last = (count == CNT_W'(ITER - 1)) || ((mplier >> 1) == '0);
`else
    assign last = count == CNT_W'(ITER - 1);
`endif
    assign bus.product = product;
    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.zero = product == '0;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            mcand <= '0;
            mplier <= '0;
            neg <= 1'b0;
            acc <= '0;
            count <= '0;
            product <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                BUSY: begin
                    acc <= acc_next;
                    mplier <= mplier >> 1;
                    count <= count + CNT_W'(1);
                    if (last) begin
                        product <= neg ? -acc_next : acc_next;
                        busy <= 1'b0;
                        done <= 1'b1;
                        state <= DONE;
                    end
                end
                // IDLE and DONE both accept a new operation
                default: begin
                    if (bus.start) begin
                        mcand <= a_mag;
                        mplier <= b_mag;
                        neg <= a_sign ^ b_sign;
                        acc <= '0;
                        count <= '0;
                        busy <= 1'b1;
                        state <= BUSY;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: scoreboard bench for seq_multiplier; expected products queued at issue, compared on done.
module tb_seq_multiplier;
    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_p;

    always #5 clk = ~clk;

    seq_multiplier_if #(.DATA_W(16)) bus ();
    seq_multiplier dut (.clk(clk), .reset(reset), .bus(bus.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y);
        int p;
        p = $signed(x) * $signed(y);
        return p[15:0];
    endfunction

    function automatic int latency(input logic [7:0] y);
        logic [7:0] m;
        int h;
        m = y[7] ? -y : y;
        h = 0;
        for (int i = 0; i < 8; i++) if (m[i]) h = i + 1;
`ifdef MULT_EARLY_TERM_EN
        return (h < 1 ? 1 : h) + 1;
`else
        return 9;
`endif
    endfunction

    always @(negedge clk) begin
        if (!reset && bus.done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", bus.done, 0);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                check("product", bus.product, e);
                check("zero", bus.zero, e == 16'h0);
                last_p = e;
            end
        end
    end

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit noise);
        int n;
        int lat;
        @(negedge clk);
        bus.a = a;
        bus.b = b;
        bus.start = 1'b1;
        exp_q.push_back(model(a[7:0], b[7:0]));
        lat = latency(b[7:0]);
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        while (!bus.done && n < 20) begin
            check("busy", bus.busy, 1);
            check("held_product", bus.product, last_p);
            bus.start = noise && lat == 9 && (n == 3 || n == 5);
            if (bus.start) begin
                bus.a = 16'($urandom);
                bus.b = 16'($urandom);
            end
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        check("latency", n, lat);
    endtask

    task automatic run_b2b(input logic [15:0] a1, input logic [15:0] b1, input logic [15:0] a2, input logic [15:0] b2);
        int n;
        int lat1;
        @(negedge clk);
        bus.a = a1;
        bus.b = b1;
        bus.start = 1'b1;
        exp_q.push_back(model(a1[7:0], b1[7:0]));
        lat1 = latency(b1[7:0]);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < 20);
        check("b2b_lat1", n, lat1);
        bus.a = a2;
        bus.b = b2;
        exp_q.push_back(model(a2[7:0], b2[7:0]));
        @(negedge clk);
        bus.start = 1'b0;
        n++;
        while (!bus.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2b_lat2", n, lat1 + latency(b2[7:0]));
    endtask

    task automatic run_reset_mid;
        @(negedge clk);
        bus.a = 16'd100;
        bus.b = 16'd100;
        bus.start = 1'b1;
        exp_q.push_back(model(8'd100, 8'd100));
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("rst_product", bus.product, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_zero", bus.zero, 1);
        reset = 1'b0;
        last_p = 16'h0;
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        last_p = 16'h0;
        repeat (3) @(negedge clk);
        check("init_product", bus.product, 0);
        check("init_busy", bus.busy, 0);
        check("init_done", bus.done, 0);
        check("init_zero", bus.zero, 1);
        reset = 1'b0;
        run_op(16'h0003, 16'h0005, 1'b0);
        run_op(16'h1280, 16'hFF80, 1'b0);
        run_op(16'h0080, 16'h007F, 1'b0);
        run_op(16'h0025, 16'h0000, 1'b0);
        run_op(16'h0007, 16'hFFFE, 1'b1);
        repeat (3) @(negedge clk);
        check("idle_hold", bus.product, last_p);
        check("idle_busy", bus.busy, 0);
        run_reset_mid();
        run_op(16'd100, 16'd100, 1'b0);
        run_b2b(16'h0009, 16'h00F7, 16'h0002, 16'h0003);
        for (int i = 0; i < 6; i++) run_op(16'($urandom), 16'($urandom), 1'b0);
        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
